// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- parametrised raster timing generator on the system clock.
//
// A clock divider produces a one-clk pixel strobe (pix_en) every CLK_DIV
// enabled clocks. On each strobe the horizontal/vertical position advances.
// All decoded outputs are registered from the next position, so they always
// agree with x_pixel/y_pixel.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   en           run enable; low pauses divider, counters and outputs
//   pix_en       one-clk strobe on every pixel advance
//   h_sync       horizontal sync, active level HS_POL
//   v_sync       vertical sync, active level VS_POL
//   DE           data enable, high inside the visible area
//   x_pixel      horizontal position (CNT_W bits)
//   y_pixel      vertical position (CNT_W bits)
//   line_start   high for the whole pixel period where x_pixel == 0
//   frame_start  high for the whole pixel period where x_pixel == 0, y_pixel == 0
//
// Optional build macro VGA_XY_BLANK_ZERO_EN: when defined, x_pixel/y_pixel
// read 0 whenever DE is low (including reset); internal counters are unchanged.

module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 4,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int CNT_W     = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             pix_en,
  output logic             h_sync,
  output logic             v_sync,
  output logic             DE,
  output logic [CNT_W-1:0] x_pixel,
  output logic [CNT_W-1:0] y_pixel,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_VISIBLE + H_FRONT);
  // Last sync pixel (inclusive) so the constant never needs H_TOTAL to fit.
  localparam logic [CNT_W-1:0] H_SL   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] V_SL   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Elaboration-time parameter legality checks.
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  if (H_VISIBLE < 1 || H_SYNC < 1 || V_VISIBLE < 1 || V_SYNC < 1) begin : g_bad_width
    $error("vga_timing_gen: visible and sync widths must be at least 1");
  end
  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_cnt_w
    $error("vga_timing_gen: CNT_W too small for H_TOTAL-1 / V_TOTAL-1");
  end

  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic             h_wrap;
  logic             de_next;
  logic             hs_act;
  logic             vs_act;

  // Next position and the decodes of that position.
  always_comb begin
    h_wrap  = (h_cnt == H_LAST);
    h_next  = h_wrap ? '0 : h_cnt + 1'b1;
    v_next  = v_cnt;
    if (h_wrap) begin
      v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end
    de_next = (h_next < H_VIS) && (v_next < V_VIS);
    hs_act  = (h_next >= H_SS) && (h_next <= H_SL);
    vs_act  = (v_next >= V_SS) && (v_next <= V_SL);
  end

`ifdef VGA_XY_BLANK_ZERO_EN
  logic [CNT_W-1:0] x_q;
  logic [CNT_W-1:0] y_q;
`endif

  // Reset parks the counters on the last position so the first pixel
  // strobe lands on (0,0). With en low nothing changes except pix_en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div         <= '0;
      pix_en      <= 1'b0;
      h_cnt       <= H_LAST;
      v_cnt       <= V_LAST;
      DE          <= 1'b0;
      h_sync      <= ~HS_POL;
      v_sync      <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
`ifdef VGA_XY_BLANK_ZERO_EN
      x_q         <= '0;
      y_q         <= '0;
`endif
    end else if (en) begin
      if (div == DIV_LAST) begin
        div         <= '0;
        pix_en      <= 1'b1;
        h_cnt       <= h_next;
        v_cnt       <= v_next;
        DE          <= de_next;
        h_sync      <= hs_act ? HS_POL : ~HS_POL;
        v_sync      <= vs_act ? VS_POL : ~VS_POL;
        line_start  <= (h_next == '0);
        frame_start <= (h_next == '0) && (v_next == '0);
`ifdef VGA_XY_BLANK_ZERO_EN
        x_q         <= de_next ? h_next : '0;
        y_q         <= de_next ? v_next : '0;
`endif
      end else begin
        div    <= div + 1'b1;
        pix_en <= 1'b0;
      end
    end else begin
      pix_en <= 1'b0;
    end
  end

`ifdef VGA_XY_BLANK_ZERO_EN
  assign x_pixel = x_q;
  assign y_pixel = y_q;
`else
  assign x_pixel = h_cnt;
  assign y_pixel = v_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen -- bench for vga_timing_gen.
// Two instances share clk/reset/en: "A" (CLK_DIV=3, mixed polarity) and
// "B" (tiny raster, CLK_DIV=1, active-high syncs). A reference model derives
// every output from the count of enabled clocks since reset.

module tb_vga_timing_gen;

  localparam int CW = 5;

  typedef struct {
    int div;
    int hvis, hfr, hsy, hbk;
    int vvis, vfr, vsy, vbk;
    bit hpol, vpol;
  } cfg_t;

  typedef struct packed {
    logic          pix_en;
    logic          hs;
    logic          vs;
    logic          de;
    logic          ls;
    logic          fs;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } out_t;

  typedef struct {
    int   n;
    out_t exp;
  } vec_t;

  cfg_t cfg_a = '{div: 3, hvis: 8, hfr: 2, hsy: 3, hbk: 2,
                  vvis: 5, vfr: 1, vsy: 2, vbk: 2, hpol: 1'b0, vpol: 1'b1};
  cfg_t cfg_b = '{div: 1, hvis: 4, hfr: 1, hsy: 1, hbk: 1,
                  vvis: 2, vfr: 1, vsy: 1, vbk: 1, hpol: 1'b1, vpol: 1'b1};

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic en;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          pix_en_a, hs_a, vs_a, de_a, ls_a, fs_a;
  logic [CW-1:0] x_a, y_a;
  logic          pix_en_b, hs_b, vs_b, de_b, ls_b, fs_b;
  logic [CW-1:0] x_b, y_b;

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .CLK_DIV(3), .HS_POL(1'b0), .VS_POL(1'b1), .CNT_W(CW)
  ) dut_a (
    .clk(clk), .reset(rst), .en(en), .pix_en(pix_en_a),
    .h_sync(hs_a), .v_sync(vs_a), .DE(de_a), .x_pixel(x_a), .y_pixel(y_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(CW)
  ) dut_b (
    .clk(clk), .reset(rst), .en(en), .pix_en(pix_en_b),
    .h_sync(hs_b), .v_sync(vs_b), .DE(de_b), .x_pixel(x_b), .y_pixel(y_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  // ---------------- reference model ----------------
  int   e_cnt;   // enabled clock edges since reset
  logic le;      // en was high at the last edge
  int   cyc = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_cnt <= 0;
      le    <= 1'b0;
    end else begin
      le <= en;
      if (en) e_cnt <= e_cnt + 1;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic out_t model(cfg_t c, int e, logic l);
    out_t o;
    int ht, vt, n, q, x, y;
    ht = c.hvis + c.hfr + c.hsy + c.hbk;
    vt = c.vvis + c.vfr + c.vsy + c.vbk;
    n  = e / c.div;
    o.pix_en = l && (e > 0) && (e % c.div == 0);
    if (n == 0) begin
      x = ht - 1; y = vt - 1;
      o.de = 1'b0; o.hs = ~c.hpol; o.vs = ~c.vpol; o.ls = 1'b0; o.fs = 1'b0;
    end else begin
      q = (n - 1) % (ht * vt);
      x = q % ht;
      y = q / ht;
      o.de = (x < c.hvis) && (y < c.vvis);
      o.hs = (x >= c.hvis + c.hfr && x < c.hvis + c.hfr + c.hsy) ? c.hpol : ~c.hpol;
      o.vs = (y >= c.vvis + c.vfr && y < c.vvis + c.vfr + c.vsy) ? c.vpol : ~c.vpol;
      o.ls = (x == 0);
      o.fs = (x == 0) && (y == 0);
    end
`ifdef VGA_XY_BLANK_ZERO_EN
    if (!o.de) begin
      x = 0; y = 0;
    end
`endif
    o.x = CW'(x);
    o.y = CW'(y);
    return o;
  endfunction

  function automatic out_t act_a();
    out_t o;
    o.pix_en = pix_en_a; o.hs = hs_a; o.vs = vs_a; o.de = de_a;
    o.ls = ls_a; o.fs = fs_a; o.x = x_a; o.y = y_a;
    return o;
  endfunction

  function automatic out_t act_b();
    out_t o;
    o.pix_en = pix_en_b; o.hs = hs_b; o.vs = vs_b; o.de = de_b;
    o.ls = ls_b; o.fs = fs_b; o.x = x_b; o.y = y_b;
    return o;
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  function automatic string fmt(out_t o);
    return $sformatf("pe=%b hs=%b vs=%b de=%b ls=%b fs=%b x=%0d y=%0d",
                     o.pix_en, o.hs, o.vs, o.de, o.ls, o.fs, o.x, o.y);
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %s, expected %s", name, $time, fmt(act), fmt(exp));
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
  endtask

  // Continuous comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("model_a", act_a(), model(cfg_a, e_cnt, le));
      check("model_b", act_b(), model(cfg_b, e_cnt, le));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input logic en_after);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    en  = en_after;
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       return ls_a;
      1:       return fs_a;
      default: return fs_b;
    endcase
  endfunction

  // Waits for a rising edge of the selected pulse; returns the clk count.
  task automatic wait_rise(input int which, input int limit, output int t);
    logic prev, cur;
    prev = sel(which);
    t = -1;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      cur = sel(which);
      if (cur && !prev) begin
        t = cyc;
        break;
      end
      prev = cur;
    end
    if (t < 0) begin
      n_checks++;
      $display("FAIL wait_rise_%0d: no rise within %0d clks, required one", which, limit);
    end
  endtask

  function automatic vec_t mk(int n, logic pe, logic hs, logic vs, logic de,
                              logic ls, logic fs, int x, int y);
    vec_t v;
    v.n = n;
    v.exp.pix_en = pe; v.exp.hs = hs; v.exp.vs = vs; v.exp.de = de;
    v.exp.ls = ls; v.exp.fs = fs; v.exp.x = CW'(x); v.exp.y = CW'(y);
    return v;
  endfunction

  // ---------------- test ----------------
  vec_t tbl[12];
  int   t0, t1, k, held;

  initial begin
    // Instance B, hand-derived: 7-pixel lines, 5-line frames, syncs active high.
    //            n  pe hs vs de ls fs  x  y
    tbl[0]  = mk( 0, 0, 0, 0, 0, 0, 0, 6, 4);
    tbl[1]  = mk( 1, 1, 0, 0, 1, 1, 1, 0, 0);
    tbl[2]  = mk( 4, 1, 0, 0, 1, 0, 0, 3, 0);
    tbl[3]  = mk( 5, 1, 0, 0, 0, 0, 0, 4, 0);
    tbl[4]  = mk( 6, 1, 1, 0, 0, 0, 0, 5, 0);
    tbl[5]  = mk( 7, 1, 0, 0, 0, 0, 0, 6, 0);
    tbl[6]  = mk( 8, 1, 0, 0, 1, 1, 0, 0, 1);
    tbl[7]  = mk(15, 1, 0, 0, 0, 1, 0, 0, 2);
    tbl[8]  = mk(22, 1, 0, 1, 0, 1, 0, 0, 3);
    tbl[9]  = mk(27, 1, 1, 1, 0, 0, 0, 5, 3);
    tbl[10] = mk(29, 1, 0, 0, 0, 1, 0, 0, 4);
    tbl[11] = mk(36, 1, 0, 0, 1, 1, 1, 0, 0);

    rst = 1'b1;
    en  = 1'b0;
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Table: reset, run n enabled clocks, compare instance B.
    for (int i = 0; i < 12; i++) begin
      out_t exp;
      exp = tbl[i].exp;
`ifdef VGA_XY_BLANK_ZERO_EN
      if (!exp.de) begin
        exp.x = '0; exp.y = '0;
      end
`endif
      do_reset(tbl[i].n > 0);
      repeat (tbl[i].n) @(negedge clk);
      en = 1'b0;
      check($sformatf("table_b_n%0d", tbl[i].n), act_b(), exp);
    end

    // First strobe after reset on instance A, and start pulses held one pixel.
    do_reset(1'b1);
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (pix_en_a) begin
        k = i;
        break;
      end
    end
    check_int("first_pix_en_clk", k, 3);
    held = 0;
    for (int i = 0; i < 10; i++) begin
      if (ls_a && fs_a) held++;
      else break;
      @(negedge clk);
    end
    check_int("start_pulse_hold", held, 3);

    // Line and frame periods with en held high.
    wait_rise(0, 200, t0);
    wait_rise(0, 200, t1);
    check_int("line_period_a", t1 - t0, 45);
    wait_rise(1, 600, t0);
    wait_rise(1, 600, t1);
    check_int("frame_period_a", t1 - t0, 450);
    wait_rise(2, 100, t0);
    wait_rise(2, 100, t1);
    check_int("frame_period_b", t1 - t0, 35);

    // Pause for 10 clks at x=4 on a visible line.
    wait_rise(1, 600, t0);
    for (int i = 0; i < 50; i++) begin
      if (x_a == CW'(4)) break;
      @(negedge clk);
    end
    check_int("pause_start_x", int'(x_a), 4);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_int("pause_hold_x", int'(x_a), 4);
      check_int("pause_pix_en", int'(pix_en_a), 0);
    end
    en = 1'b1;
    wait_rise(0, 200, t1);
    check_int("paused_line_period", t1 - t0, 55);

    // Randomised run with occasional asynchronous resets mid-frame.
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      en = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b1;
        #1;
        check("async_reset_a", act_a(), model(cfg_a, e_cnt, le));
        check("async_reset_b", act_b(), model(cfg_b, e_cnt, le));
        @(negedge clk);
        rst = 1'b0;
      end
    end

    // Deterministic asynchronous reset mid-line.
    en = 1'b1;
    repeat (200) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset_final_a", act_a(), model(cfg_a, 0, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA/HDMI-style raster timing generator, the successor to the fixed 640x480 decoder.
- Runs on the system clock. Produces a pixel-rate strobe instead of a derived clock.
- Supports arbitrary porch, sync and visible timings, selectable sync polarity, run/pause control, and frame/line start pulses.
- Sits between the system clock and the frame-buffer readout and display formatter.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
CLK_DIV, 4, clk cycles per pixel (>=1)
HS_POL, 0, h_sync active level (0 = active-low)
VS_POL, 0, v_sync active level
CNT_W, 10, width of x/y counters; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
en  in  1  run enable; low = pause, all state held
pix_en  out  1  one-clk strobe marking a pixel advance
h_sync  out  1  horizontal sync, level per HS_POL
v_sync  out  1  vertical sync, level per VS_POL
DE  out  1  data enable, high in visible area
x_pixel  out  CNT_W  horizontal position
y_pixel  out  CNT_W  vertical position
line_start  out  1  high for one pix_en period while x_pixel==0
frame_start  out  1  high for one pix_en period while x_pixel==0 and y_pixel==0

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Derived totals: H_TOTAL = sum of the four H parameters; V_TOTAL likewise for V.
- Reset values:
  - divider = 0, pix_en = 0.
  - h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1, so x_pixel = H_TOTAL-1 and y_pixel = V_TOTAL-1.
  - DE = 0, both syncs at their inactive level, line_start = 0, frame_start = 0.
- Divider:
  - Counts 0..CLK_DIV-1 while en=1.
  - pix_en is registered and asserted on the clk where the divider wraps.
  - With CLK_DIV=1, pix_en = en delayed by one clk.
- Counters advance on the same edge pix_en rises:
  - h_cnt wraps H_TOTAL-1 -> 0.
  - v_cnt increments only on h wrap, and wraps V_TOTAL-1 -> 0.
  - The first pix_en after reset moves the position to (0,0).
- All outputs are registered and decoded from the next counter values, so they are always coherent with x_pixel/y_pixel.
  - DE = (x < H_VISIBLE) and (y < V_VISIBLE).
  - h_sync is active for H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC.
  - v_sync is active for the analogous line range, whole lines, changing only at x=0.
- line_start and frame_start are held for the full pixel period (CLK_DIV clks), not a single clk.
- Pause (en=0):
  - Divider, counters and all outputs hold; pix_en = 0.
  - On resume, counting continues from the held divider value with no skipped or duplicated pixel.
- Reset mid-frame: immediate asynchronous return to the reset values. Restart is identical to power-up.
- No dependence on clk frequency. Parameter legality is checked by elaboration-time assertions; illegal values are undefined behaviour.

Optional Feature:
Macro VGA_XY_BLANK_ZERO_EN.
- Defined: x_pixel and y_pixel read 0 whenever DE=0, including the reset state. Internal counters are unaffected.
- Undefined: x_pixel and y_pixel always show the raw counters over the full range.
- DE, syncs and start pulses are identical in both builds.

Test Plan:
- Defaults; release reset with en=1 -> first pix_en on the 4th clk after release; x=0, y=0, DE=1, line_start=1, frame_start=1, each held 4 clks.
- Defaults, run one line -> h_sync low exactly for x 656..751 (96 strobes, 384 clks); DE low from x=640 to 799; 3200 clks between line_start rises.
- Defaults, run two frames -> v_sync low for lines 490..491; frame_start rises exactly 1,680,000 clks apart; y wraps 524 -> 0.
- Drop en for 10 clks at x=300 -> pix_en stays 0 and outputs hold; after resume x=301 appears with the correct residual divider phase; line period becomes 3210 clks.
- Override H=4/1/1/1, V=2/1/1/1, CLK_DIV=1, HS_POL=1, VS_POL=1 -> line of 7 pixels; h_sync high only at x=5; v_sync high only at y=3; frame_start every 35 clks.
- Assert reset at x=700, y=200 -> outputs return to reset values asynchronously; with VGA_XY_BLANK_ZERO_EN defined, x and y read 0 during reset and blanking.
